// File: rtl/dmem_request.sv
// dmem_request: MEM-stage data-cache request controller.
//
// Turns the EX/MEM load/store enables into a held cache request, stalls the
// upstream pipeline until the cache acknowledges with dhit, and hands the
// captured load data to the MEM/WB latch.
//
// Optional feature: define LLSC_EN to add load-linked / store-conditional
// support. This adds a link register and the LL_in, SC_in, snoop_inv and
// snoop_addr inputs. Without the macro, those ports and the link register
// do not exist.
//
// Ports
//   CLK, nRST              clock, synchronous active-low reset
//   memREN_in, memWEN_in   load / store request from EX/MEM (store wins)
//   addr_in, store_in      byte address and store data
//   flush                  squash of the MEM-stage instruction (IDLE only)
//   dhit, dmemload         cache acknowledge and read data
//   dmemREN, dmemWEN       cache strobes, high for the whole REQ state
//   dmemaddr, dmemstore    registered cache address / store data
//   mem_stall              freezes PC, IF/ID, ID/EX and EX/MEM
//   dmemload_out           captured load data (or SC success flag)
//   done                   one-cycle completion pulse
//   misalign               one-cycle pulse on a misaligned request
//   LL_in, SC_in           (LLSC_EN) load-linked / store-conditional
//   snoop_inv, snoop_addr  (LLSC_EN) remote invalidate that breaks the link
module dmem_request (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        memREN_in,
  input  logic        memWEN_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_in,
  input  logic        flush,
  input  logic        dhit,
  input  logic [31:0] dmemload,
`ifdef LLSC_EN
  input  logic        LL_in,
  input  logic        SC_in,
  input  logic        snoop_inv,
  input  logic [31:0] snoop_addr,
`endif
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic [31:0] dmemload_out,
  output logic        done,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic [31:0] load_q, load_d;
  logic        is_store_q, is_store_d;

  logic access;
  logic request;

  assign access  = memREN_in | memWEN_in;
  assign request = access & ~flush & (addr_in[1:0] == 2'b00);

`ifdef LLSC_EN
  logic        link_valid_q, link_valid_d;
  logic [29:0] link_addr_q, link_addr_d;
  logic        is_sc_q, is_sc_d;
  logic        is_ll_q, is_ll_d;
  logic        link_set, link_clr;
  logic        unused_snoop_lsb;

  assign unused_snoop_lsb = ^snoop_addr[1:0];
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    store_d    = store_q;
    load_d     = load_q;
    is_store_d = is_store_q;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    mem_stall  = 1'b0;
    done       = 1'b0;
    misalign   = 1'b0;
`ifdef LLSC_EN
    is_sc_d      = is_sc_q;
    is_ll_d      = is_ll_q;
    link_set     = 1'b0;
    link_clr     = 1'b0;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
`endif

    case (state_q)
      IDLE: begin
        // Outputs are gated by nRST so nothing leaks out while held in reset.
        misalign = nRST & access & ~flush & (addr_in[1:0] != 2'b00);
        if (request) begin
          mem_stall  = nRST;
          addr_d     = addr_in;
          store_d    = store_in;
          is_store_d = memWEN_in;
          state_d    = REQ;
`ifdef LLSC_EN
          is_sc_d = memWEN_in & SC_in;
          is_ll_d = ~memWEN_in & LL_in;
          // A failing SC never touches the cache; it completes next cycle
          // with a zero result.
          if (memWEN_in && SC_in &&
              !(link_valid_q && (addr_in[31:2] == link_addr_q))) begin
            state_d  = DONE;
            load_d   = 32'd0;
            link_clr = 1'b1;
          end
`endif
        end
      end

      REQ: begin
        mem_stall = 1'b1;
        dmemREN   = ~is_store_q;
        dmemWEN   = is_store_q;
        if (dhit) begin
          state_d = DONE;
          if (!is_store_q) load_d = dmemload;
`ifdef LLSC_EN
          if (is_sc_q) begin
            load_d   = 32'd1;
            link_clr = 1'b1;
          end
          if (is_store_q && (addr_q[31:2] == link_addr_q)) link_clr = 1'b1;
          if (is_ll_q) link_set = 1'b1;
`endif
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

`ifdef LLSC_EN
    if (link_set) begin
      link_valid_d = 1'b1;
      link_addr_d  = addr_q[31:2];
    end
    if (link_clr) link_valid_d = 1'b0;
    // Compared against the post-update address so a snoop on the line being
    // linked this very cycle still kills the link.
    if (snoop_inv && (snoop_addr[31:2] == link_addr_d)) link_valid_d = 1'b0;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      store_q    <= 32'd0;
      load_q     <= 32'd0;
      is_store_q <= 1'b0;
`ifdef LLSC_EN
      is_sc_q      <= 1'b0;
      is_ll_q      <= 1'b0;
      link_valid_q <= 1'b0;
      link_addr_q  <= 30'd0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      store_q    <= store_d;
      load_q     <= load_d;
      is_store_q <= is_store_d;
`ifdef LLSC_EN
      is_sc_q      <= is_sc_d;
      is_ll_q      <= is_ll_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
`endif
    end
  end

  assign dmemaddr     = addr_q;
  assign dmemstore    = store_q;
  assign dmemload_out = load_q;

endmodule

// File: doc/dmem_request.md
DMEM_REQUEST -- requirements
Module: dmem_request

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 nRST  input  1  reset, synchronous, active-low, sampled on rising CLK.
REQ-003 memREN_in  input  1  EX/MEM stage load request.
REQ-004 memWEN_in  input  1  EX/MEM stage store request.
REQ-005 addr_in  input  32  byte address from ALU output.
REQ-006 store_in  input  32  store data.
REQ-007 flush  input  1  squash of the current MEM-stage instruction.
REQ-008 dhit  input  1  cache acknowledge; load data valid on dmemload when high.
REQ-009 dmemload  input  32  cache read data.
REQ-010 dmemREN / dmemWEN  output  1 each  cache read/write strobes.
REQ-011 dmemaddr / dmemstore  output  32 each  registered cache address/data.
REQ-012 mem_stall  output  1  holds PC, IF/ID, ID/EX and EX/MEM latches.
REQ-013 dmemload_out  output  32  captured load or SC result, feeds the MEM/WB dmemload_in field.
REQ-014 done  output  1  one-cycle pulse; access complete.
REQ-015 misalign  output  1  one-cycle pulse; addr_in[1:0] != 0 on a request.

Function
REQ-016 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-017 IDLE: request = (memREN_in | memWEN_in) & ~flush & (addr_in[1:0]==0); on request latch addr_in/store_in into dmemaddr/dmemstore and go to REQ.
REQ-018 memWEN_in has priority when both enables are high: access is a store.
REQ-019 Misaligned request in IDLE: no cache access, misalign=1 for one cycle, stay IDLE, mem_stall low.
REQ-020 REQ: dmemREN or dmemWEN held high and address/data held stable until dhit; then capture dmemload into dmemload_out (loads only) and go to DONE.
REQ-021 Stores leave dmemload_out unchanged.
REQ-022 DONE: done=1, strobes low, mem_stall low; unconditional return to IDLE.
REQ-023 mem_stall = (IDLE & request) | REQ; low in DONE, so pipeline advances exactly once per access.
REQ-024 Minimum access latency: 3 cycles IDLE->REQ->DONE with dhit in first REQ cycle; no upper bound while dhit stays low.
REQ-025 flush while in REQ or DONE is ignored; an issued cache access always completes.
REQ-026 dhit outside REQ is ignored.

Reset
REQ-027 nRST low at a rising edge: state IDLE; dmemREN, dmemWEN, done, misalign, mem_stall = 0; dmemaddr, dmemstore, dmemload_out = 0.
REQ-028 Reset during REQ abandons the access; no done pulse is produced.

Configuration
REQ-029 Macro LLSC_EN defined: extra inputs LL_in, SC_in (1 bit), snoop_inv (1), snoop_addr (32); internal link_valid and link_addr[31:2].
REQ-030 LLSC_EN: completed LL load sets link_valid=1, link_addr=addr[31:2].
REQ-031 LLSC_EN: SC with link_valid & address match issues a normal store, and dmemload_out=1 at DONE; on mismatch, no cache access, IDLE->DONE in one cycle, dmemload_out=0.
REQ-032 LLSC_EN: link_valid cleared by any completed SC, by any completed store to link_addr, and by snoop_inv with snoop_addr[31:2]==link_addr; snoop clear wins over a simultaneous LL set.
REQ-033 LLSC_EN undefined: LL/SC ports absent; all loads and stores behave per REQ-017..026.

Verification
REQ-034 Load addr 0x0000_0040, dhit in 1st REQ cycle, dmemload=0xDEAD_BEEF -> dmemREN 1 cycle, done in cycle 3, dmemload_out=0xDEAD_BEEF, mem_stall high cycles 1-2.
REQ-035 Store addr 0x100, data 0x1234_5678, dhit delayed 5 cycles -> dmemWEN and dmemaddr/dmemstore stable 5 cycles, mem_stall high 6 cycles, dmemload_out unchanged.
REQ-036 Load addr 0x0000_0042 -> misalign pulse, no strobes, mem_stall low, state IDLE.
REQ-037 nRST low in REQ cycle 2 with dhit low -> next cycle all outputs 0, IDLE, no done.
REQ-038 LLSC_EN: LL 0x200, SC 0x200 -> store issued, dmemload_out=1; repeat SC 0x200 -> no dmemWEN, dmemload_out=0.
REQ-039 LLSC_EN: LL 0x300, snoop_inv with snoop_addr=0x300, then SC 0x300 -> no dmemWEN, dmemload_out=0.
